// File: rtl/icache_fetch.sv
// Direct-mapped, one-word-per-line instruction cache between IF and memory-controller port 0.
// Optional hit/miss counters are compiled in with ICACHE_STATS_EN.
module icache_fetch #(
    parameter int INDEX_BITS = 6
) (
    input  logic        clk_in,
    input  logic        rst_in,
    input  logic        rdy_in,
    input  logic        if_req,
    input  logic [31:0] if_pc,
    output logic        if_ready,
    output logic        if_valid,
    output logic [31:0] if_inst,
    input  logic        flush,
    output logic        mc_re,
    output logic [31:0] mc_addr,
    output logic [2:0]  mc_len,
    input  logic        mc_busy,
    input  logic        mc_done,
    input  logic [31:0] mc_rdata
`ifdef ICACHE_STATS_EN
    ,
    output logic [31:0] hit_cnt,
    output logic [31:0] miss_cnt
`endif
);

    localparam int TAG_W = 30 - INDEX_BITS;
    localparam int LINES = 1 << INDEX_BITS;

    localparam logic [1:0] S_IDLE      = 2'd0;
    localparam logic [1:0] S_MISS_REQ  = 2'd1;
    localparam logic [1:0] S_MISS_WAIT = 2'd2;

    logic [1:0]            state;
    logic [29:0]           word_q;
    logic                  discard_q;
    logic [LINES-1:0]      valid_q;
    logic [TAG_W-1:0]      tag_mem  [LINES];
    logic [31:0]           data_mem [LINES];

    logic [INDEX_BITS-1:0] req_idx;
    logic [TAG_W-1:0]      req_tag;
    logic [INDEX_BITS-1:0] lat_idx;
    logic [TAG_W-1:0]      lat_tag;
    logic                  hit;
    logic                  accept;
    logic                  fill;
    logic                  unused_pc_bits;

    assign req_idx        = if_pc[INDEX_BITS+1:2];
    assign req_tag        = if_pc[31:INDEX_BITS+2];
    assign lat_idx        = word_q[INDEX_BITS-1:0];
    assign lat_tag        = word_q[29:INDEX_BITS];
    assign unused_pc_bits = ^if_pc[1:0];

    assign hit    = valid_q[req_idx] && (tag_mem[req_idx] == req_tag);
    assign accept = rdy_in && (state == S_IDLE) && if_req && !flush;
    // A flush seen at any point of the miss, including the mc_done cycle, suppresses the fill.
    assign fill   = rdy_in && (state == S_MISS_WAIT) && mc_done && !discard_q && !flush;

    assign if_ready = (state == S_IDLE);
    assign mc_len   = 3'd4;

    always_ff @(posedge clk_in) begin
        if (fill) begin
            tag_mem[lat_idx]  <= lat_tag;
            data_mem[lat_idx] <= mc_rdata;
        end
    end

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            state     <= S_IDLE;
            word_q    <= '0;
            discard_q <= 1'b0;
            valid_q   <= '0;
            if_valid  <= 1'b0;
            if_inst   <= '0;
            mc_re     <= 1'b0;
            mc_addr   <= '0;
        end else if (rdy_in) begin
            if_valid <= 1'b0;
            mc_re    <= 1'b0;
            if (flush) begin
                valid_q <= '0;
            end else if (fill) begin
                valid_q[lat_idx] <= 1'b1;
            end
            case (state)
                S_IDLE: begin
                    if (accept) begin
                        word_q <= if_pc[31:2];
                        if (hit) begin
                            if_valid <= 1'b1;
                            if_inst  <= data_mem[req_idx];
                        end else begin
                            state <= S_MISS_REQ;
                        end
                    end
                end
                S_MISS_REQ: begin
                    if (flush) begin
                        state <= S_IDLE;
                    end else if (!mc_busy) begin
                        mc_re     <= 1'b1;
                        mc_addr   <= {word_q, 2'b00};
                        discard_q <= 1'b0;
                        state     <= S_MISS_WAIT;
                    end
                end
                S_MISS_WAIT: begin
                    if (flush) begin
                        discard_q <= 1'b1;
                    end
                    if (mc_done) begin
                        if (fill) begin
                            if_valid <= 1'b1;
                            if_inst  <= mc_rdata;
                        end
                        discard_q <= 1'b0;
                        state     <= S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

`ifdef ICACHE_STATS_EN
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            hit_cnt  <= '0;
            miss_cnt <= '0;
        end else if (accept) begin
            if (hit) begin
                hit_cnt <= hit_cnt + 32'd1;
            end else begin
                miss_cnt <= miss_cnt + 32'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_icache_fetch.sv
// Self-checking bench for icache_fetch: directed scenarios plus randomized fetches against
// a line-level cache model and a behavioural memory.
module tb_icache_fetch;

    logic        clk_in = 1'b0;
    logic        rst_in = 1'b1;
    logic        rdy_in = 1'b1;
    logic        if_req = 1'b0;
    logic [31:0] if_pc = '0;
    logic        if_ready;
    logic        if_valid;
    logic [31:0] if_inst;
    logic        flush = 1'b0;
    logic        mc_re;
    logic [31:0] mc_addr;
    logic [2:0]  mc_len;
    logic        mc_busy = 1'b0;
    logic        mc_done = 1'b0;
    logic [31:0] mc_rdata = '0;
`ifdef ICACHE_STATS_EN
    logic [31:0] hit_cnt;
    logic [31:0] miss_cnt;
`endif

    icache_fetch #(.INDEX_BITS(6)) dut (
        .clk_in(clk_in), .rst_in(rst_in), .rdy_in(rdy_in),
        .if_req(if_req), .if_pc(if_pc), .if_ready(if_ready),
        .if_valid(if_valid), .if_inst(if_inst), .flush(flush),
        .mc_re(mc_re), .mc_addr(mc_addr), .mc_len(mc_len),
        .mc_busy(mc_busy), .mc_done(mc_done), .mc_rdata(mc_rdata)
`ifdef ICACHE_STATS_EN
        , .hit_cnt(hit_cnt), .miss_cnt(miss_cnt)
`endif
    );

    always #5 clk_in = ~clk_in;

    int total = 0;
    int bad = 0;
    int re_cnt = 0;
    int val_cnt = 0;
    int exp_re = 0;
    int exp_val = 0;
    int exp_hits = 0;
    int exp_misses = 0;

    // Model: which word address each of the 64 lines currently holds.
    bit          mdl_v    [64];
    logic [29:0] mdl_word [64];

    always @(negedge clk_in) begin
        if (mc_re === 1'b1) re_cnt++;
        if (if_valid === 1'b1) val_cnt++;
    end

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        if (a == 32'h100) return 32'h00A00093;
        return (a * 32'h9E3779B1) ^ 32'hA5A50F0F;
    endfunction

    function automatic bit mdl_hit(input logic [31:0] a);
        int idx;
        idx = int'((a >> 2) % 64);
        return mdl_v[idx] && (mdl_word[idx] == a[31:2]);
    endfunction

    task automatic mdl_fill(input logic [31:0] a);
        int idx;
        idx = int'((a >> 2) % 64);
        mdl_v[idx]    = 1'b1;
        mdl_word[idx] = a[31:2];
    endtask

    task automatic mdl_clear();
        for (int i = 0; i < 64; i++) mdl_v[i] = 1'b0;
    endtask

    task automatic wait_ready();
        int k;
        for (k = 0; k < 30 && if_ready !== 1'b1; k++) @(negedge clk_in);
        total++;
        if (if_ready !== 1'b1) begin
            bad++;
            $display("FAIL wait_ready: if_ready=%b required 1 within 30 cycles", if_ready);
        end
    endtask

    task automatic wait_mc_re(input string name);
        int k;
        for (k = 0; k < 20 && mc_re !== 1'b1; k++) @(negedge clk_in);
        total++;
        if (mc_re !== 1'b1) begin
            bad++;
            $display("FAIL %s mc_re timeout: mc_re=%b required 1", name, mc_re);
        end
    endtask

    task automatic fetch(input logic [31:0] pc, input int busy_cyc, input int lat);
        logic [31:0] w;
        bit hit;
        w = pc & 32'hFFFF_FFFC;
        hit = mdl_hit(w);
        wait_ready();
        if_req  = 1'b1;
        if_pc   = w | 32'($urandom_range(0, 3));
        mc_busy = (busy_cyc > 0);
        @(negedge clk_in);
        if_req = 1'b0;
        if (hit) begin
            mc_busy = 1'b0;
            exp_hits++;
            exp_val++;
            total++;
            if (if_valid !== 1'b1 || if_inst !== mem_word(w) || if_ready !== 1'b1) begin
                bad++;
                $display("FAIL hit %h: valid=%b inst=%h ready=%b required 1 %h 1",
                         w, if_valid, if_inst, if_ready, mem_word(w));
            end
        end else begin
            exp_misses++;
            total++;
            if (if_valid !== 1'b0 || if_ready !== 1'b0) begin
                bad++;
                $display("FAIL miss_accept %h: valid=%b ready=%b required 0 0", w, if_valid, if_ready);
            end
            for (int k = 0; k < busy_cyc; k++) begin
                total++;
                if (mc_re !== 1'b0) begin
                    bad++;
                    $display("FAIL busy_hold %h: mc_re=%b required 0", w, mc_re);
                end
                @(negedge clk_in);
            end
            mc_busy = 1'b0;
            wait_mc_re("miss");
            exp_re++;
            total++;
            if (mc_addr !== w || mc_len !== 3'd4) begin
                bad++;
                $display("FAIL mc_req: addr=%h len=%0d required %h 4", mc_addr, mc_len, w);
            end
            @(negedge clk_in);
            total++;
            if (mc_re !== 1'b0) begin
                bad++;
                $display("FAIL mc_re_pulse: mc_re=%b required 0", mc_re);
            end
            repeat (lat) @(negedge clk_in);
            mc_done  = 1'b1;
            mc_rdata = mem_word(w);
            @(negedge clk_in);
            mc_done  = 1'b0;
            mc_rdata = $urandom;
            exp_val++;
            total++;
            if (if_valid !== 1'b1 || if_inst !== mem_word(w) || if_ready !== 1'b1) begin
                bad++;
                $display("FAIL fill %h: valid=%b inst=%h ready=%b required 1 %h 1",
                         w, if_valid, if_inst, if_ready, mem_word(w));
            end
            mdl_fill(w);
        end
        @(negedge clk_in);
    endtask

    task automatic test_reset();
        @(negedge clk_in);
        total++;
        if (if_ready !== 1'b1 || if_valid !== 1'b0 || if_inst !== 32'h0 ||
            mc_re !== 1'b0 || mc_addr !== 32'h0 || mc_len !== 3'd4) begin
            bad++;
            $display("FAIL reset: ready=%b valid=%b inst=%h re=%b addr=%h len=%0d required 1 0 0 0 0 4",
                     if_ready, if_valid, if_inst, mc_re, mc_addr, mc_len);
        end
        rst_in = 1'b0;
        mdl_clear();
        @(negedge clk_in);
    endtask

    task automatic test_miss_fill();
        fetch(32'h100, 0, 4);
    endtask

    task automatic test_hit_and_busy();
        fetch(32'h100, 0, 0);
        fetch(32'h104, 3, 2);
    endtask

    task automatic test_conflict();
        fetch(32'h200, 0, 1);
        fetch(32'h100, 0, 1);
    endtask

    task automatic test_flush();
        int k;
        // flush during MISS_WAIT
        wait_ready();
        if_req = 1'b1;
        if_pc  = 32'h340;
        @(negedge clk_in);
        if_req = 1'b0;
        exp_misses++;
        wait_mc_re("flush_wait");
        exp_re++;
        flush = 1'b1;
        @(negedge clk_in);
        flush = 1'b0;
        mdl_clear();
        repeat (2) @(negedge clk_in);
        mc_done  = 1'b1;
        mc_rdata = 32'hDEAD_BEEF;
        @(negedge clk_in);
        mc_done = 1'b0;
        total++;
        if (if_valid !== 1'b0 || if_ready !== 1'b1) begin
            bad++;
            $display("FAIL flush_wait: valid=%b ready=%b required 0 1", if_valid, if_ready);
        end
        @(negedge clk_in);
        fetch(32'h340, 0, 1);
        fetch(32'h100, 0, 0);

        // flush during MISS_REQ
        if_req  = 1'b1;
        if_pc   = 32'h480;
        mc_busy = 1'b1;
        @(negedge clk_in);
        if_req = 1'b0;
        exp_misses++;
        flush = 1'b1;
        @(negedge clk_in);
        flush = 1'b0;
        mdl_clear();
        total++;
        if (if_ready !== 1'b1 || mc_re !== 1'b0) begin
            bad++;
            $display("FAIL flush_req: ready=%b re=%b required 1 0", if_ready, mc_re);
        end
        mc_busy = 1'b0;
        repeat (3) @(negedge clk_in);
        total++;
        if (re_cnt !== exp_re) begin
            bad++;
            $display("FAIL flush_req_no_re: mc_re pulses=%0d required %0d", re_cnt, exp_re);
        end

        // flush in IDLE together with a request that would hit
        fetch(32'h100, 0, 0);
        k = val_cnt;
        if_req = 1'b1;
        if_pc  = 32'h100;
        flush  = 1'b1;
        @(negedge clk_in);
        if_req = 1'b0;
        flush  = 1'b0;
        mdl_clear();
        total++;
        if (if_valid !== 1'b0 || if_ready !== 1'b1 || val_cnt !== k) begin
            bad++;
            $display("FAIL flush_idle: valid=%b ready=%b required 0 1", if_valid, if_ready);
        end
        fetch(32'h100, 0, 0);
    endtask

    task automatic test_back_to_back();
        logic [31:0] pcs [3];
        pcs[0] = 32'h0;
        pcs[1] = 32'h4;
        pcs[2] = 32'h8;
        for (int i = 0; i < 3; i++) fetch(pcs[i], 0, 0);
        wait_ready();
        if_req = 1'b1;
        if_pc  = pcs[0];
        for (int i = 0; i < 3; i++) begin
            @(negedge clk_in);
            if (i < 2) if_pc = pcs[i+1];
            else if_req = 1'b0;
            exp_hits++;
            exp_val++;
            total++;
            if (if_valid !== 1'b1 || if_inst !== mem_word(pcs[i])) begin
                bad++;
                $display("FAIL back_to_back[%0d]: valid=%b inst=%h required 1 %h",
                         i, if_valid, if_inst, mem_word(pcs[i]));
            end
        end
        @(negedge clk_in);
    endtask

    task automatic test_rdy_hold();
        @(negedge clk_in);
        rdy_in = 1'b0;
        if_req = 1'b1;
        if_pc  = 32'h4;
        repeat (2) begin
            @(negedge clk_in);
            total++;
            if (if_valid !== 1'b0 || if_ready !== 1'b1) begin
                bad++;
                $display("FAIL rdy_hold: valid=%b ready=%b required 0 1", if_valid, if_ready);
            end
        end
        rdy_in = 1'b1;
        @(negedge clk_in);
        if_req = 1'b0;
        exp_hits++;
        exp_val++;
        total++;
        if (if_valid !== 1'b1 || if_inst !== mem_word(32'h4)) begin
            bad++;
            $display("FAIL rdy_release: valid=%b inst=%h required 1 %h", if_valid, if_inst, mem_word(32'h4));
        end
        @(negedge clk_in);
    endtask

    task automatic test_stray_done();
        mc_done  = 1'b1;
        mc_rdata = 32'h1234_5678;
        @(negedge clk_in);
        mc_done = 1'b0;
        total++;
        if (if_valid !== 1'b0 || if_ready !== 1'b1) begin
            bad++;
            $display("FAIL stray_done: valid=%b ready=%b required 0 1", if_valid, if_ready);
        end
        fetch(32'h8, 0, 0);
    endtask

    task automatic test_random();
        logic [31:0] pc;
        for (int i = 0; i < 40; i++) begin
            pc = 32'($urandom_range(0, 15) * 4 + $urandom_range(0, 3) * 256);
            fetch(pc, $urandom_range(0, 2), $urandom_range(0, 4));
        end
    endtask

    task automatic test_reset_mid_miss();
        wait_ready();
        if_req = 1'b1;
        if_pc  = 32'h5C0;
        @(negedge clk_in);
        if_req = 1'b0;
        wait_mc_re("reset_mid_miss");
        exp_re++;
        #2 rst_in = 1'b1;
        #1;
        total++;
        if (if_ready !== 1'b1 || mc_re !== 1'b0 || mc_addr !== 32'h0 || if_valid !== 1'b0) begin
            bad++;
            $display("FAIL reset_mid_miss: ready=%b re=%b addr=%h valid=%b required 1 0 0 0",
                     if_ready, mc_re, mc_addr, if_valid);
        end
        @(negedge clk_in);
        rst_in = 1'b0;
        mdl_clear();
        exp_hits   = 0;
        exp_misses = 0;
        mc_done  = 1'b1;
        mc_rdata = 32'hCAFE_F00D;
        @(negedge clk_in);
        mc_done = 1'b0;
        total++;
        if (if_valid !== 1'b0 || if_ready !== 1'b1) begin
            bad++;
            $display("FAIL post_reset_done: valid=%b ready=%b required 0 1", if_valid, if_ready);
        end
        fetch(32'h100, 0, 0);
        fetch(32'h100, 0, 0);
    endtask

    initial begin
        test_reset();
        test_miss_fill();
        test_hit_and_busy();
        test_conflict();
`ifdef ICACHE_STATS_EN
        total++;
        if (hit_cnt !== 32'(exp_hits) || miss_cnt !== 32'(exp_misses)) begin
            bad++;
            $display("FAIL stats_early: hit=%0d miss=%0d required %0d %0d",
                     hit_cnt, miss_cnt, exp_hits, exp_misses);
        end
`endif
        test_flush();
        test_back_to_back();
        test_rdy_hold();
        test_stray_done();
        test_random();
        test_reset_mid_miss();
        repeat (2) @(negedge clk_in);
        total++;
        if (re_cnt !== exp_re) begin
            bad++;
            $display("FAIL mc_re_count: got %0d required %0d", re_cnt, exp_re);
        end
        total++;
        if (val_cnt !== exp_val) begin
            bad++;
            $display("FAIL if_valid_count: got %0d required %0d", val_cnt, exp_val);
        end
`ifdef ICACHE_STATS_EN
        total++;
        if (hit_cnt !== 32'(exp_hits) || miss_cnt !== 32'(exp_misses)) begin
            bad++;
            $display("FAIL stats_final: hit=%0d miss=%0d required %0d %0d",
                     hit_cnt, miss_cnt, exp_hits, exp_misses);
        end
`endif
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
